// File: rtl/seg_display_arbiter.sv
// Two-requester round-robin writer for a double-buffered 4-digit multiplexed
// seven-segment display with dwell/brightness scan. Optional: `LEADING_ZERO_BLANK_EN.
module seg_display_arbiter #(
  parameter int DWELL_CYCLES = 8,
  parameter int CNT_W        = 4
) (
  input  logic        div_clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [19:0] data_a,
  input  logic        req_b,
  input  logic [19:0] data_b,
  input  logic [2:0]  brightness,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  owner_e           last_grant_q, last_grant_d;
  logic [19:0]      shadow_q, shadow_d;
  logic [19:0]      active_q, active_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             grant_a, grant_b;
  logic             dwell_wrap, frame_edge, slot_on;
  logic [3:0]       digit_nib, dp_en;
  logic [3:0]       lz_blank;

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Round robin: on contention the side that did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if (last_grant_q == OWNER_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    shadow_d     = shadow_q;
    gnt_a_d      = grant_a;
    gnt_b_d      = grant_b;
    if (grant_a) begin
      shadow_d     = data_a;
      last_grant_d = OWNER_A;
    end else if (grant_b) begin
      shadow_d     = data_b;
      last_grant_d = OWNER_B;
    end
  end

  // Active takes the pre-edge shadow, so a same-edge grant waits a frame.
  always_comb begin
    dwell_wrap  = (dwell_cnt_q == DWELL_LAST);
    frame_edge  = dwell_wrap && (digit_idx_q == 2'd3);
    dwell_cnt_d = dwell_wrap ? '0 : dwell_cnt_q + CNT_W'(1);
    digit_idx_d = dwell_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    active_d    = frame_edge ? shadow_q : active_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero.
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lz
    assign lz_blank[gi] = (active_d[15:4*gi] == '0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  // Outputs are driven from the post-edge counter and frame values.
  always_comb begin
    digit_nib = active_d[{digit_idx_d, 2'b00} +: 4];
    dp_en     = active_d[19:16];
    slot_on   = (32'(dwell_cnt_d) <= 32'(brightness));
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    dp_d      = 1'b1;
    if (slot_on) begin
      an_d  = ~(4'b0001 << digit_idx_d);
      seg_d = lz_blank[digit_idx_d] ? 7'b1111111 : hex7seg(digit_nib);
      dp_d  = ~dp_en[digit_idx_d];
    end
  end

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWNER_B;
      shadow_q     <= '0;
      active_q     <= '0;
      dwell_cnt_q  <= DWELL_LAST;
      digit_idx_q  <= 2'd3;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      dwell_cnt_q  <= dwell_cnt_d;
      digit_idx_q  <= digit_idx_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: stimulus queues expected grants and
// display slots; one monitor process pops and compares as the DUT presents them.
module tb_seg_display_arbiter;

  logic        div_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        req_a   = 1'b0;
  logic        req_b   = 1'b0;
  logic [19:0] data_a  = '0;
  logic [19:0] data_b  = '0;
  logic [2:0]  brightness = 3'd7;
  logic        gnt_a, gnt_b;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_display_arbiter #(.DWELL_CYCLES(8), .CNT_W(4)) dut (
    .div_clk    (div_clk),
    .reset      (reset),
    .req_a      (req_a),
    .data_a     (data_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .brightness (brightness),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 div_clk = ~div_clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'b1111111;
`else
  localparam logic [6:0] ZB = 7'b1000000;
`endif
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] SF = 7'b0001110;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [4:0] len;
  } slot_t;

  slot_t slot_q[$];
  bit    gnt_q[$];
  bit    mon_en = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  // Edge number since reset release; frames start on edges 1, 33, 65, ...
  always @(posedge div_clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant pulses and display slots.
  initial begin
    slot_t cur;
    bit    have_cur;
    int    on_cnt;
    logic [3:0] prev_an;
    bit    g;
    have_cur = 1'b0;
    on_cnt   = 0;
    prev_an  = 4'hF;
    forever begin
      @(negedge div_clk);
      if (gnt_a || gnt_b) begin
        if (gnt_a && gnt_b) begin
          checks++; errors++;
          $display("FAIL gnt_both: got gnt_a=1 gnt_b=1 expected one");
        end else if (gnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: got gnt_a=%0b gnt_b=%0b expected none", gnt_a, gnt_b);
        end else begin
          g = gnt_q.pop_front();
          check("gnt_owner_is_b", 32'(gnt_b), 32'(g));
          $display("grant %s at edge %0d", gnt_b ? "B" : "A", cyc);
        end
      end
      if (!mon_en) begin
        prev_an  = 4'hF;
        have_cur = 1'b0;
        on_cnt   = 0;
      end else begin
        if (an != 4'hF) begin
          if (an != prev_an) begin
            if (have_cur) check("slot_len", 32'(on_cnt), 32'(cur.len));
            if (slot_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_slot: got an=%b expected none", an);
              have_cur = 1'b0;
            end else begin
              cur = slot_q.pop_front();
              have_cur = 1'b1;
              $display("slot an=%b seg=%b dp=%b at edge %0d", an, seg, dp, cyc);
            end
            on_cnt = 0;
          end
          on_cnt++;
          if (have_cur) begin
            check("slot_an", 32'(an), 32'(cur.an));
            check("slot_seg", 32'(seg), 32'(cur.seg));
            check("slot_dp", 32'(dp), 32'(cur.dp));
          end
        end else begin
          check("off_seg", 32'(seg), 32'h7F);
          check("off_dp", 32'(dp), 32'h1);
        end
        prev_an = an;
      end
    end
  end

  task automatic step();
    @(posedge div_clk);
    #1;
  endtask

  // Call on the first edge of a frame; dpn holds the expected dp pin per digit.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [3:0] dpn, input logic [2:0] bri);
    logic [4:0] len;
    len = 5'(bri) + 5'd1;
    slot_q.push_back('{an: 4'b1110, seg: s0, dp: dpn[0], len: len});
    slot_q.push_back('{an: 4'b1101, seg: s1, dp: dpn[1], len: len});
    slot_q.push_back('{an: 4'b1011, seg: s2, dp: dpn[2], len: len});
    slot_q.push_back('{an: 4'b0111, seg: s3, dp: dpn[3], len: len});
    brightness = bri;
    mon_en     = 1'b1;
    repeat (32) step();
  endtask

  task automatic request(input bit is_b, input logic [19:0] d);
    int n;
    gnt_q.push_back(is_b);
    if (is_b) begin req_b = 1'b1; data_b = d; end
    else      begin req_a = 1'b1; data_a = d; end
    n = 0;
    do begin
      step();
      n++;
    end while (!(is_b ? gnt_b : gnt_a) && n < 8);
    if (!(is_b ? gnt_b : gnt_a)) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no grant expected grant to %s", is_b ? "B" : "A");
    end
    if (is_b) req_b = 1'b0;
    else      req_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge div_clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_gnt_a", 32'(gnt_a), 32'h0);
    check("rst_gnt_b", 32'(gnt_b), 32'h0);

    // Contention for edges 1..6: A,B,A,B,A,B; B's data (8) is left in shadow.
    req_a = 1'b1; data_a = 20'h0_0001;
    req_b = 1'b1; data_b = 20'h0_0008;
    for (int i = 0; i < 6; i++) gnt_q.push_back(i[0]);
    reset = 1'b0;
    step();
    fork
      run_frame(S0, ZB, ZB, ZB, 4'hF, 3'd7);
      begin
        repeat (5) step();
        req_a = 1'b0;
        req_b = 1'b0;
      end
    join
    run_frame(7'b0000000, ZB, ZB, ZB, 4'hF, 3'd7);
    fork
      run_frame(7'b0000000, ZB, ZB, ZB, 4'hF, 3'd7);
      request(1'b0, 20'h1_2345);
    join
    // Shadow cleared early, then 0xFFFF granted exactly on the frame-wrap edge 129.
    fork
      run_frame(7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 4'b1110, 3'd7);
      begin
        request(1'b0, 20'h0_0000);
        while (cyc != 128) step();
        request(1'b1, 20'h0_FFFF);
      end
    join
    run_frame(S0, ZB, ZB, ZB, 4'hF, 3'd7);
    run_frame(SF, SF, SF, SF, 4'hF, 3'd7);
    run_frame(SF, SF, SF, SF, 4'hF, 3'd2);
    fork
      run_frame(SF, SF, SF, SF, 4'hF, 3'd7);
      request(1'b0, 20'h0_0070);
    join
    run_frame(S0, 7'b1111000, ZB, ZB, 4'hF, 3'd7);

    // Mid-frame reset while digit1 is lit; the request held during reset must be dropped.
    mon_en = 1'b0;
    repeat (11) step();
    check("pre_rst_an", 32'(an), 32'hD);
    reset = 1'b1;
    req_a = 1'b1;
    data_a = 20'h1_1111;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_dp", 32'(dp), 32'h1);
    repeat (4) step();
    check("hold_rst_an", 32'(an), 32'hF);
    check("hold_rst_gnt_a", 32'(gnt_a), 32'h0);
    req_a = 1'b0;
    reset = 1'b0;
    step();
    run_frame(S0, ZB, ZB, ZB, 4'hF, 3'd7);
    run_frame(S0, ZB, ZB, ZB, 4'hF, 3'd7);
    mon_en = 1'b0;
    step();

    check("slot_q_empty", 32'(slot_q.size()), 32'h0);
    check("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
